rvcpu_run_ctrl: RTL
===================

RVCPU_RUN_CTRL -- requirements
Module: rvcpu_run_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 2, meaning number of clk cycles cpu_rst is held high after leaving reset/restart (range 1..2^CNT_W-1).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000, meaning RUN cycles before declaring timeout (range 1..2^CNT_W-1).
REQ-003 SHALL have parameter CNT_W, default 32, meaning cycle/retire counter width.
REQ-004 SHALL have parameters ADDR_W=32 and DATA_W=32, meaning monitored store-bus widths.
REQ-005 SHALL have parameter TOHOST_ADDR, default 32'h0000_1000, meaning the store address that signals test completion.
REQ-006 clk input 1: single clock; all state changes on rising edge.
REQ-007 rst input 1: asynchronous, active-high reset.
REQ-008 restart input 1: synchronous single-cycle request to rerun the test.
REQ-009 instr_retire input 1: CPU retired one instruction this cycle.
REQ-010 mem_we input 1: CPU data-store strobe.
REQ-011 mem_addr input ADDR_W: store address.
REQ-012 mem_wdata input DATA_W: store data.
REQ-013 cpu_rst output 1: reset driven to the CPU core.
REQ-014 done output 1: test finished (pass, fail or timeout).
REQ-015 pass output 1: test passed; valid when done=1.
REQ-016 timeout output 1: test ended by timeout; valid when done=1.
REQ-017 fail_code output DATA_W-1: mem_wdata[DATA_W-1:1] of the failing tohost store; 0 otherwise.
REQ-018 cycle_cnt output CNT_W: clk cycles spent in RUN.
REQ-019 retire_cnt output CNT_W: instr_retire pulses counted in RUN.

Function
REQ-020 FSM states SHALL be HOLD, RUN, PASS, FAIL, TIMEOUT.
REQ-021 HOLD: cpu_rst=1, hold counter increments each cycle; on count reaching RST_CYCLES-1 -> RUN next cycle (cpu_rst high exactly RST_CYCLES cycles).
REQ-022 RUN: cpu_rst=0; cycle_cnt increments every cycle; retire_cnt increments when instr_retire=1.
REQ-023 RUN, mem_we=1 and mem_addr==TOHOST_ADDR: wdata==1 -> PASS; wdata[0]==1 and wdata!=1 -> FAIL, fail_code latched; wdata[0]==0 -> ignored, stay RUN.
REQ-024 RUN, cycle_cnt==TIMEOUT_CYCLES-1 with no qualifying tohost store that cycle -> TIMEOUT; a qualifying store in the same cycle SHALL win over timeout.
REQ-025 PASS/FAIL/TIMEOUT are terminal: done=1, counters frozen, cpu_rst=1 (core held), further stores and retires ignored.
REQ-026 pass=1 only in PASS; timeout=1 only in TIMEOUT; FAIL has done=1, pass=0, timeout=0.
REQ-027 restart=1 in any state SHALL next cycle enter HOLD, clear hold counter, cycle_cnt, retire_cnt, fail_code; restart overrides all other transitions that cycle.
REQ-028 Counters SHALL saturate at 2^CNT_W-1, never wrap.
REQ-029 Outputs SHALL be registered (state-decoded from registered state); no combinational input-to-output path.
REQ-030 Stores with mem_addr!=TOHOST_ADDR SHALL have no effect in any state.

Reset
REQ-031 rst=1 SHALL asynchronously force state=HOLD, hold counter=0, cpu_rst=1, done=0, pass=0, timeout=0, fail_code=0, cycle_cnt=0, retire_cnt=0.
REQ-032 After rst deasserts, sequence SHALL be identical to a restart (REQ-021 timing from first rising edge).
REQ-033 rst asserted mid-RUN SHALL abort the test with no done indication.

Structure
REQ-034 State encoding enum and default TOHOST_ADDR/PASS code constant SHALL live in shared package rvcpu_sim_pkg.
REQ-035 A saturating counter sub-module sat_counter (parameter W; inputs clr, en) SHALL be instantiated for cycle_cnt, retire_cnt and hold counter.
REQ-036 Block SHALL be synthesizable; no delays, no $finish inside.

Verification
REQ-037 Defaults, rst released at t=10ns -> cpu_rst high for exactly 2 cycles after release, then low; cycle_cnt counts from 0.
REQ-038 In RUN, 5 retire pulses then store 32'h1 to 32'h1000 -> done=1, pass=1, retire_cnt=5, cpu_rst=1 next cycle.
REQ-039 Store 32'h7 to 32'h1000 -> done=1, pass=0, fail_code=3; store 32'h2 to 32'h1000 earlier -> ignored.
REQ-040 TIMEOUT_CYCLES=10, no tohost store -> timeout=1 after 10 RUN cycles, cycle_cnt=9 frozen; with store 32'h1 on cycle 9 -> pass=1, timeout=0.
REQ-041 CNT_W=4, TIMEOUT_CYCLES=15, retire every cycle -> retire_cnt saturates at 15 and holds.
REQ-042 restart pulse in PASS, and rst pulse mid-RUN -> HOLD, all counters 0, done=0, cpu_rst high for RST_CYCLES.

Source files
------------

// File: rtl/rvcpu_sim_pkg.sv
// rtl/rvcpu_sim_pkg.sv - shared run-control state encoding and tohost constants
package rvcpu_sim_pkg;

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } run_state_t;

  localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_1000;
  localparam logic [31:0] PASS_CODE           = 32'h0000_0001;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up-counter that sticks at all-ones; clr has priority over en
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/rvcpu_run_ctrl.sv
// rtl/rvcpu_run_ctrl.sv - holds the core in reset, runs it, and watches tohost for the verdict
module rvcpu_run_ctrl
  import rvcpu_sim_pkg::*;
#(
  parameter int                RST_CYCLES     = 2,
  parameter int                TIMEOUT_CYCLES = 1000,
  parameter int                CNT_W          = 32,
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR    = ADDR_W'(TOHOST_ADDR_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic              instr_retire,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [DATA_W-2:0] fail_code,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  retire_cnt
);

  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  RUN_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_W-1:0] PASS_VAL  = DATA_W'(PASS_CODE);

  run_state_t        state_q, state_d;
  logic [DATA_W-2:0] fail_code_q, fail_code_d;
  logic [CNT_W-1:0]  hold_cnt;
  logic              tohost_hit;
  logic              hold_en, cycle_en, retire_en;

  always_comb begin
    state_d     = state_q;
    fail_code_d = fail_code_q;
    tohost_hit  = mem_we && (mem_addr == TOHOST_ADDR);
    case (state_q)
      ST_HOLD: begin
        if (hold_cnt == HOLD_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        // A verdict store in the last RUN cycle beats the timeout.
        if (tohost_hit && (mem_wdata == PASS_VAL)) begin
          state_d = ST_PASS;
        end else if (tohost_hit && mem_wdata[0]) begin
          state_d     = ST_FAIL;
          fail_code_d = mem_wdata[DATA_W-1:1];
        end else if (cycle_cnt == RUN_LAST) begin
          state_d = ST_TIMEOUT;
        end
      end
      ST_PASS, ST_FAIL, ST_TIMEOUT: state_d = state_q;
      default: state_d = ST_HOLD;
    endcase
    if (restart) begin
      state_d     = ST_HOLD;
      fail_code_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_HOLD;
      fail_code_q <= '0;
    end else begin
      state_q     <= state_d;
      fail_code_q <= fail_code_d;
    end
  end

  // cycle_cnt stops on the cycle the run ends, so it freezes at the last RUN index.
  assign hold_en   = (state_q == ST_HOLD) && !restart;
  assign cycle_en  = (state_q == ST_RUN) && (state_d == ST_RUN);
  assign retire_en = (state_q == ST_RUN) && instr_retire && !restart;

  sat_counter #(.W(CNT_W)) u_hold_cnt (
    .clk (clk),
    .rst (rst),
    .clr (restart),
    .en  (hold_en),
    .cnt (hold_cnt)
  );

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .clr (restart),
    .en  (cycle_en),
    .cnt (cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk (clk),
    .rst (rst),
    .clr (restart),
    .en  (retire_en),
    .cnt (retire_cnt)
  );

  assign cpu_rst   = (state_q != ST_RUN);
  assign done      = (state_q == ST_PASS) || (state_q == ST_FAIL) || (state_q == ST_TIMEOUT);
  assign pass      = (state_q == ST_PASS);
  assign timeout   = (state_q == ST_TIMEOUT);
  assign fail_code = fail_code_q;

endmodule
